// File: rtl/lif_neuron_array.sv
// Time-multiplexed leaky integrate-and-fire neuron array: one shared update datapath,
// per-neuron potential/refractory registers, 1-cycle latency, valid/ready on both sides.
module lif_neuron_array #(
    parameter int WIDTH       = 16,
    parameter int NUM_NEURONS = 8,
    parameter int REFRAC_W    = 4,
    localparam int ID_W       = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1,
    localparam int PW         = 2 * WIDTH
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic [WIDTH-1:0]    leak_factor,
    input  logic [WIDTH-1:0]    threshold,
    input  logic [WIDTH-1:0]    reset_potential,
    input  logic [REFRAC_W-1:0] refrac_period,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ID_W-1:0]     in_id,
    input  logic [WIDTH-1:0]    in_current,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ID_W-1:0]     out_id,
    output logic                out_spike,
    output logic [WIDTH-1:0]    out_potential
);

    logic [WIDTH-1:0]    v_q  [NUM_NEURONS];
    logic [REFRAC_W-1:0] rc_q [NUM_NEURONS];

    logic                out_valid_q;
    logic [ID_W-1:0]     out_id_q;
    logic                out_spike_q;
    logic [WIDTH-1:0]    out_potential_q;

    logic                accept;
    logic                id_ok;
    logic [WIDTH-1:0]    v_cur;
    logic [REFRAC_W-1:0] rc_cur;
    logic [WIDTH-1:0]    leak;
    logic [WIDTH:0]      sum;
    logic [WIDTH-1:0]    vn;
    logic [WIDTH-1:0]    v_d;
    logic [REFRAC_W-1:0] rc_d;
    logic                spike_d;
    logic [WIDTH-1:0]    pot_d;

    assign id_ok    = ({1'b0, in_id} < (ID_W + 1)'(NUM_NEURONS));
    assign in_ready = !clear && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        v_cur   = '0;
        rc_cur  = '0;
        if (id_ok) begin
            v_cur  = v_q[in_id];
            rc_cur = rc_q[in_id];
        end
        // leak <= v_cur always, so the subtraction cannot wrap; only the add can overflow
        leak = WIDTH'((PW'(v_cur) * PW'(leak_factor)) >> WIDTH);
        sum  = {1'b0, v_cur} - {1'b0, leak} + {1'b0, in_current};
        vn   = sum[WIDTH] ? '1 : sum[WIDTH-1:0];

        v_d     = v_cur;
        rc_d    = rc_cur;
        spike_d = 1'b0;
        pot_d   = '0;
        if (id_ok) begin
            if (rc_cur != '0) begin
                rc_d  = rc_cur - REFRAC_W'(1);
                pot_d = v_cur;
            end else if (vn >= threshold) begin
                spike_d = 1'b1;
                v_d     = reset_potential;
                rc_d    = refrac_period;
                pot_d   = reset_potential;
            end else begin
                v_d   = vn;
                pot_d = vn;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                v_q[i]  <= '0;
                rc_q[i] <= '0;
            end
            out_valid_q     <= 1'b0;
            out_id_q        <= '0;
            out_spike_q     <= 1'b0;
            out_potential_q <= '0;
        end else if (clear) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                v_q[i]  <= '0;
                rc_q[i] <= '0;
            end
            out_valid_q <= 1'b0;
        end else if (accept) begin
            if (id_ok) begin
                v_q[in_id]  <= v_d;
                rc_q[in_id] <= rc_d;
            end
            out_valid_q     <= 1'b1;
            out_id_q        <= in_id;
            out_spike_q     <= spike_d;
            out_potential_q <= pot_d;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_id        = out_id_q;
    assign out_spike     = out_spike_q;
    assign out_potential = out_potential_q;

endmodule

// File: tb/tb_lif_neuron_array.sv
// Scoreboard bench for lif_neuron_array (6 neurons so ids 6/7 exercise the invalid-id path).
module tb_lif_neuron_array;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic [15:0] leak_factor = '0;
    logic [15:0] threshold = 16'd100;
    logic [15:0] reset_potential = 16'd5;
    logic [3:0]  refrac_period = 4'd2;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_id = '0;
    logic [15:0] in_current = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [2:0]  out_id;
    logic        out_spike;
    logic [15:0] out_potential;

    typedef struct packed {
        logic [2:0]  id;
        logic        spk;
        logic [15:0] pot;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    lif_neuron_array #(.WIDTH(16), .NUM_NEURONS(6), .REFRAC_W(4)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .leak_factor(leak_factor), .threshold(threshold),
        .reset_potential(reset_potential), .refrac_period(refrac_period),
        .in_valid(in_valid), .in_ready(in_ready), .in_id(in_id), .in_current(in_current),
        .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
        .out_spike(out_spike), .out_potential(out_potential)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: a result is consumed at the edge following a negedge with valid && ready.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", {12'd0, out_id, out_spike, out_potential}, 32'hFFFFFFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("result{id,spk,pot}", {12'd0, out_id, out_spike, out_potential}, {12'd0, e});
                end
            end
        end
    end

    task automatic send(input logic [2:0] id, input logic [15:0] cur,
                        input logic es, input logic [15:0] ep);
        int n;
        @(posedge clk); #1;
        in_valid = 1'b1; in_id = id; in_current = cur;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("send_timeout", 32'd0, 32'd1);
        else exp_q.push_back({id, es, ep});
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #3;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_id", {29'd0, out_id}, 32'd0);
        chk("rst_out_spike", {31'd0, out_spike}, 32'd0);
        chk("rst_out_pot", {16'd0, out_potential}, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // integrate, no leak, threshold 100
        send(3'd2, 16'd30, 1'b0, 16'd30);
        send(3'd2, 16'd30, 1'b0, 16'd60);
        send(3'd2, 16'd30, 1'b0, 16'd90);
        send(3'd3, 16'd0,  1'b0, 16'd0);
        // fire, then two refractory updates
        send(3'd2, 16'd30, 1'b1, 16'd5);
        send(3'd2, 16'd50, 1'b0, 16'd5);
        send(3'd2, 16'd50, 1'b0, 16'd5);
        send(3'd2, 16'd50, 1'b0, 16'd55);
        // threshold equality fires; just below does not
        refrac_period = 4'd0;
        send(3'd0, 16'd100, 1'b1, 16'd5);
        send(3'd1, 16'd99,  1'b0, 16'd99);
        // leak
        threshold = 16'hFFFF;
        send(3'd4, 16'h8000, 1'b0, 16'h8000);
        leak_factor = 16'h8000;
        send(3'd4, 16'h0000, 1'b0, 16'h4000);
        send(3'd4, 16'h0010, 1'b0, 16'h2010);
        // saturation clamps to 0xFFFF which meets threshold 0xFFFF
        leak_factor = 16'h0000;
        reset_potential = 16'h1234;
        send(3'd5, 16'hFFF0, 1'b0, 16'hFFF0);
        send(3'd5, 16'h0100, 1'b1, 16'h1234);
        // invalid ids leave state untouched
        send(3'd7, 16'd50,   1'b0, 16'd0);
        send(3'd6, 16'hFFFF, 1'b0, 16'd0);
        send(3'd2, 16'd0, 1'b0, 16'd55);
        send(3'd5, 16'd0, 1'b0, 16'h1234);
        send(3'd1, 16'd0, 1'b0, 16'd99);

        // backpressure
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(3'd3, 16'd7, 1'b0, 16'd7);
        in_valid = 1'b1; in_id = 3'd3; in_current = 16'd3;
        repeat (5) begin
            @(negedge clk);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_hold_pot", {16'd0, out_potential}, 32'd7);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
        if (in_ready) exp_q.push_back({3'd3, 1'b0, 16'd10});
        @(posedge clk); #1;
        in_valid = 1'b0;

        // charge every neuron, then clear
        send(3'd0, 16'd1, 1'b0, 16'd6);
        send(3'd1, 16'd1, 1'b0, 16'd100);
        send(3'd2, 16'd1, 1'b0, 16'd56);
        send(3'd3, 16'd1, 1'b0, 16'd11);
        send(3'd4, 16'd1, 1'b0, 16'h2011);
        send(3'd5, 16'd1, 1'b0, 16'h1235);
        @(posedge clk); #1;
        clear = 1'b1;
        @(negedge clk);
        chk("clear_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        clear = 1'b0;
        chk("clear_out_valid", {31'd0, out_valid}, 32'd0);
        for (int i = 0; i < 6; i++) send(3'(i), 16'd3, 1'b0, 16'd3);

        // asynchronous reset with a result pending
        @(posedge clk); #1;
        in_valid = 1'b1; in_id = 3'd0; in_current = 16'd9;
        @(negedge clk);
        if (in_ready) exp_q.push_back({3'd0, 1'b0, 16'd12});
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("pre_reset_valid", {31'd0, out_valid}, 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("async_out_valid", {31'd0, out_valid}, 32'd0);
        chk("async_out_id", {29'd0, out_id}, 32'd0);
        chk("async_out_pot", {16'd0, out_potential}, 32'd0);
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        send(3'd0, 16'd4, 1'b0, 16'd4);

        repeat (4) @(posedge clk);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
